gate_truth_table_checker: RTL and testbench
===========================================

Name: gate_truth_table_checker

Overview:
Self-test sequencer for the two-input logic gate primitives (AND, OR, NOT, NOR, NAND, XOR, XNOR). It sits on both sides of a gate-under-test. Upstream, it drives the gate's A/B inputs through all four input combinations. Downstream, it samples the gate's Y0 output and compares each sample against a golden truth table for the selected gate. One run produces a per-vector mismatch mask and a pass flag.

Parameters:
SETTLE_CYCLES, 1, cycles to wait after driving a vector before sampling y_in; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request a run; sampled only in IDLE.
gate_sel  input  3  gate under test: 0=AND, 1=OR, 2=NOT (Y0=~A), 3=NOR, 4=NAND, 5=XOR, 6=XNOR, 7=reserved.
y_in  input  1  Y0 output of the gate-under-test.
a_out  output  1  drives the gate's A input.
b_out  output  1  drives the gate's B input.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when results are valid.
pass  output  1  1 when the last run had no mismatches; held until the next accepted start.
fail_mask  output  4  bit i set when vector i mismatched; held until the next accepted start.
err_sel  output  1  last accepted start used gate_sel=7; held until the next accepted start.

Behaviour:
- All outputs are registered.
- Reset: on a clk edge with rst_n=0, state goes to IDLE and a_out, b_out, busy, done, pass, fail_mask, err_sel all become 0. Reset takes effect in any state, including mid-run; the partial run is discarded and done never pulses for it.
- Vector encoding: index i runs 0..3 with a_out=i[1] and b_out=i[0]. Sequence order is 00, 01, 10, 11.
- Golden Y0 values for i=0..3:
  - AND 0001
  - OR 0111
  - NOT 1100
  - NOR 1000
  - NAND 1110
  - XOR 0110
  - XNOR 1001
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1, gate_sel 0..6:
  - Latch gate_sel; clear fail_mask, pass, err_sel.
  - Set i=0 and drive a_out/b_out=00.
  - Load the settle counter with SETTLE_CYCLES and go to SETTLE.
- IDLE, start=1, gate_sel=7:
  - Set err_sel=1, fail_mask=4'hF, pass=0.
  - Go to DONE; a_out/b_out stay 0.
- SETTLE: decrement the counter each cycle. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (1 cycle):
  - Compare y_in with golden[latched_sel][i]; on mismatch set fail_mask[i].
  - If i=3, go to DONE.
  - Otherwise increment i, drive the new a_out/b_out, reload the counter and go to SETTLE.
- DONE (1 cycle): done=1 and pass=(fail_mask==0), computed including any bit set in the final SAMPLE. Next state is IDLE.
- Latency: start is accepted at edge E0. DONE is occupied during the cycle after edge E0+4*(SETTLE_CYCLES+1). With the default, done is high during the 9th cycle after acceptance.
- Reserved-select latency: done is high during the cycle after E0+1.
- Ignored inputs:
  - start is ignored in SETTLE, SAMPLE and DONE.
  - A start held high re-triggers only once the FSM is back in IDLE, one cycle after done.
  - gate_sel changes after acceptance are ignored.
- a_out/b_out hold the last vector (11) after a run until the next accepted start.

Test Plan:
1. Correct AND model on y_in, gate_sel=0, start pulse -> a_out/b_out step 00,01,10,11. Each vector is held 2 cycles (1 SETTLE + 1 SAMPLE). done pulses once 9 cycles after acceptance with pass=1, fail_mask=4'b0000, err_sel=0.
2. AND model on y_in, gate_sel=5 (XOR) -> fail_mask=4'b1110, pass=0 at done.
3. NOT model wired as ~B, gate_sel=2 -> fail_mask=4'b0110, pass=0.
4. gate_sel=7 -> done pulses 2 cycles after acceptance with err_sel=1, fail_mask=4'hF, pass=0; a_out/b_out never toggle. A following valid run clears err_sel.
5. start held high continuously; gate_sel switched 0->5 during a run of a correct AND model -> first run reports the AND result with pass=1. A second run is accepted the cycle after done and tests XOR, giving fail_mask=4'b1110.
6. rst_n=0 for one edge while in SETTLE of vector 2 -> next cycle all outputs are 0 and busy=0, with no done pulse. A fresh start gives a complete, correct 4-vector run.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Self-test sequencer for two-input gate primitives. Steps the gate's A/B
// inputs through 00,01,10,11, waits a settle time after each vector, samples
// the gate's Y0 output and compares it with the golden truth table of the
// selected gate. The result of each run is a per-vector mismatch mask and
// a pass flag.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic       err_sel
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [2:0] SEL_RESERVED = 3'd7;

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  logic [1:0] vec_idx;
  logic [2:0] sel_q;
  logic [3:0] golden;
  logic [3:0] sample_mask;

  // Golden Y0 for the latched gate; bit i is the expected output for vector i
  always_comb begin
    golden = 4'b0000;
    case (sel_q)
      3'd0:    golden = 4'b1000;
      3'd1:    golden = 4'b1110;
      3'd2:    golden = 4'b0011;
      3'd3:    golden = 4'b0001;
      3'd4:    golden = 4'b0111;
      3'd5:    golden = 4'b0110;
      3'd6:    golden = 4'b1001;
      default: golden = 4'b0000;
    endcase
  end

  // Mismatch mask including the vector being sampled this cycle
  always_comb begin
    sample_mask          = fail_mask;
    sample_mask[vec_idx] = fail_mask[vec_idx] | (y_in != golden[vec_idx]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a reserved select passes through one SAMPLE cycle
  // with no comparison so its done pulse lands two cycles after acceptance
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (gate_sel == SEL_RESERVED) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt <= 4'd1) begin
          next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        if (err_sel || vec_idx == 2'd3) begin
          next_state = DONE;
        end else begin
          next_state = SETTLE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and run datapath (vector index, settle counter, results)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= 4'b0000;
      err_sel    <= 1'b0;
      settle_cnt <= 4'd0;
      vec_idx    <= 2'd0;
      sel_q      <= 3'd0;
    end else begin
      done <= 1'b0;
      busy <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            pass           <= 1'b0;
            {a_out, b_out} <= 2'b00;
            vec_idx        <= 2'd0;
            if (gate_sel == SEL_RESERVED) begin
              err_sel   <= 1'b1;
              fail_mask <= 4'hF;
            end else begin
              err_sel    <= 1'b0;
              fail_mask  <= 4'h0;
              sel_q      <= gate_sel;
              settle_cnt <= CNT_LOAD;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          if (err_sel) begin
            done <= 1'b1;
            pass <= 1'b0;
          end else begin
            fail_mask <= sample_mask;
            if (vec_idx == 2'd3) begin
              done <= 1'b1;
              pass <= (sample_mask == 4'b0000);
            end else begin
              vec_idx        <= vec_idx + 2'd1;
              {a_out, b_out} <= vec_idx + 2'd1;
              settle_cnt     <= CNT_LOAD;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Self-checking bench for gate_truth_table_checker. A behavioural gate model
// drives y_in from a_out/b_out (optionally a different gate than the one
// selected, plus injected per-vector faults); expected masks and timing are
// derived from the boolean definitions of the gates.
module tb_gate_truth_table_checker;

  localparam int N = 2;
  localparam int L = 4 * (N + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] gate_sel;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic       err_sel;

  int         phys_code;
  logic [3:0] fault;
  int         checks = 0;
  int         failures = 0;

  gate_truth_table_checker #(.SETTLE_CYCLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gate_sel  (gate_sel),
    .y_in      (y_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .err_sel   (err_sel)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Boolean gate definitions; code 8 models a NOT wired to B by mistake
  function automatic logic gate_fn(input int code, input logic a, input logic b);
    case (code)
      0:       return a & b;
      1:       return a | b;
      2:       return ~a;
      3:       return ~(a | b);
      4:       return ~(a & b);
      5:       return a ^ b;
      6:       return ~(a ^ b);
      8:       return ~b;
      default: return 1'b0;
    endcase
  endfunction

  // Gate-under-test model
  assign y_in = gate_fn(phys_code, a_out, b_out) ^ fault[{a_out, b_out}];

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_a", {3'b0, a_out}, 4'd0);
    checkOutput("rst_b", {3'b0, b_out}, 4'd0);
    checkOutput("rst_busy", {3'b0, busy}, 4'd0);
    checkOutput("rst_done", {3'b0, done}, 4'd0);
    checkOutput("rst_pass", {3'b0, pass}, 4'd0);
    checkOutput("rst_mask", fail_mask, 4'd0);
    checkOutput("rst_err", {3'b0, err_sel}, 4'd0);
  endtask

  // One full run: accept, per-cycle vector/busy/done checks, final results
  task automatic applyStimulus(input logic [2:0] sel, input int phys,
                               input logic [3:0] flt, input bit hold);
    logic [3:0] exp_mask;
    logic [1:0] v;
    int         idx;
    @(negedge clk);
    checkOutput("idle_busy", {3'b0, busy}, 4'd0);
    checkOutput("idle_done", {3'b0, done}, 4'd0);
    gate_sel  = sel;
    phys_code = phys;
    fault     = flt;
    start     = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    if (sel == 3'd7) begin
      checkOutput("rsv_busy", {3'b0, busy}, 4'd1);
      checkOutput("rsv_done0", {3'b0, done}, 4'd0);
      checkOutput("rsv_vec0", {2'b0, a_out, b_out}, 4'd0);
      gate_sel = 3'($urandom_range(0, 7));
      @(negedge clk);
      checkOutput("rsv_done", {3'b0, done}, 4'd1);
      checkOutput("rsv_err", {3'b0, err_sel}, 4'd1);
      checkOutput("rsv_mask", fail_mask, 4'hF);
      checkOutput("rsv_pass", {3'b0, pass}, 4'd0);
      checkOutput("rsv_vec", {2'b0, a_out, b_out}, 4'd0);
    end else begin
      exp_mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        v = 2'(i);
        exp_mask[i] = (gate_fn(phys, v[1], v[0]) ^ flt[i]) != gate_fn(int'(sel), v[1], v[0]);
      end
      for (int k = 1; k <= L; k++) begin
        idx = (k - 1) / (N + 1);
        checkOutput("run_vec", {2'b0, a_out, b_out}, 4'(idx));
        checkOutput("run_busy", {3'b0, busy}, 4'd1);
        checkOutput("run_done", {3'b0, done}, 4'd0);
        gate_sel = 3'($urandom_range(0, 7));
        @(negedge clk);
      end
      checkOutput("end_done", {3'b0, done}, 4'd1);
      checkOutput("end_busy", {3'b0, busy}, 4'd1);
      checkOutput("end_mask", fail_mask, exp_mask);
      checkOutput("end_pass", {3'b0, pass}, {3'b0, exp_mask == 4'b0000});
      checkOutput("end_err", {3'b0, err_sel}, 4'd0);
      checkOutput("end_vec", {2'b0, a_out, b_out}, 4'd3);
    end
  endtask

  // Directed sequence followed by randomized runs
  initial begin
    int         rsel;
    int         rphys;
    logic [3:0] rflt;
    rst_n     = 1'b0;
    start     = 1'b0;
    gate_sel  = 3'd0;
    phys_code = 0;
    fault     = 4'b0000;
    repeat (2) @(negedge clk);
    checkReset();
    rst_n = 1'b1;

    $display("[TB] correct AND, wrong select XOR, NOT wired as ~B");
    applyStimulus(3'd0, 0, 4'b0000, 1'b0);
    applyStimulus(3'd5, 0, 4'b0000, 1'b0);
    applyStimulus(3'd2, 8, 4'b0000, 1'b0);

    $display("[TB] reserved select then valid run");
    applyStimulus(3'd7, 0, 4'b0000, 1'b0);
    applyStimulus(3'd1, 1, 4'b0000, 1'b0);

    $display("[TB] start held high back-to-back");
    applyStimulus(3'd0, 0, 4'b0000, 1'b1);
    applyStimulus(3'd5, 0, 4'b0000, 1'b1);
    @(negedge clk);
    start = 1'b0;

    $display("[TB] reset during vector 2 settle");
    @(negedge clk);
    gate_sel  = 3'd0;
    phys_code = 0;
    fault     = 4'b0000;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * (N + 1)) @(negedge clk);
    checkOutput("pre_rst_vec", {2'b0, a_out, b_out}, 4'd2);
    rst_n = 1'b0;
    @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clk);
      checkOutput("post_rst_done", {3'b0, done}, 4'd0);
    end
    applyStimulus(3'd0, 0, 4'b0000, 1'b0);

    $display("[TB] randomized runs");
    repeat (16) begin
      rsel  = $urandom_range(0, 7);
      rphys = $urandom_range(0, 7);
      if (rphys == 7) rphys = 8;
      rflt  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      applyStimulus(3'(rsel), rphys, rflt, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
